// File: rtl/sdram_rw_arbiter_if.sv
// Handshake bundle between the burst arbiter, the FIFO level counters and the
// SDRAM command core. The arbiter uses the master side because it issues the
// burst requests. The FIFOs and the SDRAM core use the slave side.
interface sdram_rw_arbiter_if;
    logic       init_done;
    logic [8:0] wr_length;
    logic [8:0] rd_length;
    logic [8:0] wrf_use;
    logic [8:0] rdf_use;
    logic       sdram_wr_ack;
    logic       sdram_rd_ack;
    logic       sdram_wr_req;
    logic       sdram_rd_req;
    logic       wr_burst_done;
    logic       rd_burst_done;
    logic       busy;
    logic       arb_err;

    modport master (
        input  init_done, wr_length, rd_length, wrf_use, rdf_use,
        input  sdram_wr_ack, sdram_rd_ack,
        output sdram_wr_req, sdram_rd_req, wr_burst_done, rd_burst_done,
        output busy, arb_err
    );

    modport slave (
        output init_done, wr_length, rd_length, wrf_use, rdf_use,
        output sdram_wr_ack, sdram_rd_ack,
        input  sdram_wr_req, sdram_rd_req, wr_burst_done, rd_burst_done,
        input  busy, arb_err
    );
endinterface

// File: rtl/sdram_rw_arbiter.sv
// SDRAM burst arbiter. It schedules one burst at a time, either from the write
// FIFO into SDRAM or from SDRAM into the read FIFO. It follows each burst
// through the req/ack handshake.
// Write bursts win arbitration. A streak counter lets a pending read through
// after MAX_WR_STREAK back-to-back writes.
// Optional feature: define SDRAM_ARB_TIMEOUT_EN to abort a request that never
// sees an ack within TIMEOUT cycles. The abort sets the sticky arb_err flag.
module sdram_rw_arbiter #(
    parameter int unsigned MAX_WR_STREAK = 4,
    parameter int unsigned RDF_DEPTH     = 256,
    parameter int unsigned TIMEOUT       = 1023
) (
    input  logic               clk_ref,
    input  logic               rst,
    sdram_rw_arbiter_if.master bus
);

    localparam int unsigned SW = $clog2(MAX_WR_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WR_STREAK);
    localparam logic [9:0]    DEPTH10    = 10'(RDF_DEPTH);

    // Parameter sanity: the timeout counter is 10 bits, and a zero streak
    // limit would starve writes.
    if (TIMEOUT == 0 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..1023");
    end
    if (MAX_WR_STREAK == 0 || RDF_DEPTH > 1023) begin : g_bad_cfg
        $error("MAX_WR_STREAK must be >0 and RDF_DEPTH <= 1023");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_ACK = 3'd2,
        RD_REQ = 3'd3,
        RD_ACK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;

    logic       wr_elig, rd_elig;
    logic [9:0] rdf_use10, rd_room;
    logic       in_req, cur_ack, timeout_hit;

    // The read-FIFO free space is computed at 10 bits. It clamps at zero so
    // that an over-reported rdf_use can never wrap into "lots of room".
    assign rdf_use10 = {1'b0, bus.rdf_use};
    assign rd_room   = (rdf_use10 > DEPTH10) ? 10'd0 : (DEPTH10 - rdf_use10);
    assign wr_elig   = bus.init_done && (bus.wr_length != 9'd0) && (bus.wrf_use >= bus.wr_length);
    assign rd_elig   = bus.init_done && (bus.rd_length != 9'd0) && (rd_room >= {1'b0, bus.rd_length});

    assign in_req  = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign cur_ack = (state_q == WR_REQ) ? bus.sdram_wr_ack : bus.sdram_rd_ack;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    logic [9:0] to_cnt_q, to_cnt_d;
    logic       err_q, err_d;

    assign timeout_hit = (to_cnt_q == TO_LAST);

    // Ack-wait counter: it runs only while a request waits unanswered and
    // restarts on every new request.
    always_comb begin
        to_cnt_d = 10'd0;
        err_d    = err_q;
        if (in_req && !cur_ack) begin
            if (timeout_hit) err_d    = 1'b1;
            else             to_cnt_d = to_cnt_q + 10'd1;
        end
    end

    // Timeout counter and sticky error flag registers.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            to_cnt_q <= 10'd0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.arb_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.arb_err = 1'b0;
`endif

    // Next-state logic: arbitration in IDLE, then the request phase and the
    // ack phase. Streak bookkeeping happens here as well.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        unique case (state_q)
            IDLE: begin
                if (!rd_elig) streak_d = '0;
                if (wr_elig && !((streak_q == STREAK_MAX) && rd_elig)) state_d = WR_REQ;
                else if (rd_elig)                                         state_d = RD_REQ;
            end
            WR_REQ: begin
                if (bus.sdram_wr_ack) state_d = WR_ACK;
                else if (timeout_hit) state_d = IDLE;
            end
            WR_ACK: begin
                if (!bus.sdram_wr_ack) begin
                    state_d = IDLE;
                    if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
                end
            end
            RD_REQ: begin
                if (bus.sdram_rd_ack) state_d = RD_ACK;
                else if (timeout_hit) state_d = IDLE;
            end
            RD_ACK: begin
                if (!bus.sdram_rd_ack) begin
                    state_d  = IDLE;
                    streak_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and streak registers. Reset drops any request in flight at once.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Requests come straight from the state register, so they rise the cycle
    // after the grant. Done pulses mark the cycle in which ack falls.
    assign bus.sdram_wr_req  = (state_q == WR_REQ);
    assign bus.sdram_rd_req  = (state_q == RD_REQ);
    assign bus.wr_burst_done = (state_q == WR_ACK) && !bus.sdram_wr_ack;
    assign bus.rd_burst_done = (state_q == RD_ACK) && !bus.sdram_rd_ack;
    assign bus.busy          = (state_q != IDLE);

    // in_req only feeds the timeout counter, so tie it off in the default build.
`ifndef SDRAM_ARB_TIMEOUT_EN
    logic unused_ok;
    assign unused_ok = in_req;
`endif

endmodule
